// File: rtl/ddr_out_cell_pkg.sv
// Shared definitions for the DDR output cell: capture-alignment encoding
// and the mapping from the string-valued alignment parameter.
package ddr_out_cell_pkg;

    typedef enum logic [1:0] {
        ALIGN_NONE = 2'd0,
        ALIGN_C0   = 2'd1,
        ALIGN_C1   = 2'd2
    } align_e;

    function automatic bit align_is_legal(input string s);
        return (s == "NONE") || (s == "C0") || (s == "C1");
    endfunction

    function automatic align_e align_from_string(input string s);
        if (s == "NONE") return ALIGN_NONE;
        if (s == "C1")   return ALIGN_C1;
        return ALIGN_C0;
    endfunction

endpackage

// File: rtl/ddr_out_cell_if.sv
// Data-side bundle of the DDR output cell: clock enable, the word pair and
// the double-rate output.
interface ddr_out_cell_if #(
    parameter int WIDTH = 1
);
    logic             ce;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] q;

    modport master (output ce, output data0, output data1, input q);
    modport slave  (input ce, input data0, input data1, output q);
endinterface

// File: rtl/ddr_out_bit.sv
// Single-lane DDR output register: one word per clk half, driven from a
// rising-edge register and a falling-edge register selected by clk.
module ddr_out_bit
    import ddr_out_cell_pkg::*;
#(
    parameter align_e ALIGN = ALIGN_C0,
    parameter logic   INIT  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic ce,
    input  logic data0,
    input  logic data1,
    output logic q
);

    logic r_q  = INIT;
    logic p1_q = INIT;
    logic rv_q = 1'b0;
    logic rs_q = 1'b0;
    logic f_q  = INIT;
    logic c0_q = INIT;
    logic c1_q = INIT;
    logic cv_q = 1'b0;

    logic r_d, p1_d, rv_d, rs_d;
    logic f_d, c0_d, c1_d, cv_d;

    // Rising edge: an idle cycle re-drives the low-half value so q holds steady.
    always_comb begin
        r_d  = f_q;
        p1_d = p1_q;
        rv_d = 1'b0;
        rs_d = rst | set;
        if (rst || set) begin
            r_d  = ~rst;
            p1_d = ~rst;
        end else if (ALIGN == ALIGN_C1) begin
            if (cv_q) begin
                r_d  = c0_q;
                rv_d = 1'b1;
            end
        end else if (ce) begin
            r_d  = data0;
            p1_d = data1;
            rv_d = 1'b1;
        end
    end

    always_comb begin
        f_d  = r_q;
        c0_d = c0_q;
        c1_d = c1_q;
        cv_d = 1'b0;
        if (rs_q) begin
            c0_d = r_q;
            c1_d = r_q;
        end else if (ALIGN == ALIGN_NONE) begin
            if (ce) f_d = data1;
        end else if (ALIGN == ALIGN_C0) begin
            if (rv_q) f_d = p1_q;
        end else begin
            if (rv_q) f_d = c1_q;
            if (ce) begin
                c0_d = data0;
                c1_d = data1;
                cv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_q  <= r_d;
        p1_q <= p1_d;
        rv_q <= rv_d;
        rs_q <= rs_d;
    end

    always_ff @(negedge clk) begin
        f_q  <= f_d;
        c0_q <= c0_d;
        c1_q <= c1_d;
        cv_q <= cv_d;
    end

    assign q = clk ? r_q : f_q;

endmodule

// File: rtl/ddr_out_cell.sv
// WIDTH-lane DDR output register (ODDR2 equivalent) for the DAC data path;
// each lane is an independent ddr_out_bit.
module ddr_out_cell
    import ddr_out_cell_pkg::*;
#(
    parameter int    WIDTH         = 1,
    parameter string DDR_ALIGNMENT = "C0",
    parameter logic  INIT          = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           set,
    ddr_out_cell_if.slave  bus
);

    localparam align_e ALIGN = align_from_string(DDR_ALIGNMENT);

    if (!align_is_legal(DDR_ALIGNMENT)) begin : g_bad_alignment
        $error("ddr_out_cell: DDR_ALIGNMENT must be \"NONE\", \"C0\" or \"C1\"");
    end

    logic [WIDTH-1:0] q_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ddr_out_bit #(
            .ALIGN (ALIGN),
            .INIT  (INIT)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .set   (set),
            .ce    (bus.ce),
            .data0 (bus.data0[i]),
            .data1 (bus.data1[i]),
            .q     (q_w[i])
        );
    end

    assign bus.q = q_w;

endmodule

// File: tb/tb_ddr_out_cell.sv
// Directed bench for ddr_out_cell: C0 (INIT 0 and 1), NONE and C1 instances
// share one stimulus set; each scenario checks the instance it targets.
module tb_ddr_out_cell;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        set = 1'b0;
    logic        ce  = 1'b0;
    logic [15:0] d0  = 16'h0000;
    logic [15:0] d1  = 16'h0000;

    int tests_run    = 0;
    int tests_failed = 0;

    ddr_out_cell_if #(.WIDTH(16)) if_c0   ();
    ddr_out_cell_if #(.WIDTH(16)) if_c0i  ();
    ddr_out_cell_if #(.WIDTH(16)) if_none ();
    ddr_out_cell_if #(.WIDTH(16)) if_c1   ();

    assign if_c0.ce   = ce;  assign if_c0.data0   = d0;  assign if_c0.data1   = d1;
    assign if_c0i.ce  = ce;  assign if_c0i.data0  = d0;  assign if_c0i.data1  = d1;
    assign if_none.ce = ce;  assign if_none.data0 = d0;  assign if_none.data1 = d1;
    assign if_c1.ce   = ce;  assign if_c1.data0   = d0;  assign if_c1.data1   = d1;

    ddr_out_cell #(.WIDTH(16), .DDR_ALIGNMENT("C0"), .INIT(1'b0)) u_c0 (
        .clk(clk), .rst(rst), .set(set), .bus(if_c0));
    ddr_out_cell #(.WIDTH(16), .DDR_ALIGNMENT("C0"), .INIT(1'b1)) u_c0i (
        .clk(clk), .rst(rst), .set(set), .bus(if_c0i));
    ddr_out_cell #(.WIDTH(16), .DDR_ALIGNMENT("NONE"), .INIT(1'b0)) u_none (
        .clk(clk), .rst(rst), .set(set), .bus(if_none));
    ddr_out_cell #(.WIDTH(16), .DDR_ALIGNMENT("C1"), .INIT(1'b0)) u_c1 (
        .clk(clk), .rst(rst), .set(set), .bus(if_c1));

    always #5 clk = ~clk;

    task automatic test_reset();
        #1;
        tests_run++;
        if (if_c0.q !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL powerup_c0_init0: got %h expected %h", if_c0.q, 16'h0000);
        end
        tests_run++;
        if (if_c0i.q !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL powerup_c0_init1: got %h expected %h", if_c0i.q, 16'hFFFF);
        end
        tests_run++;
        if (if_none.q !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL powerup_none: got %h expected %h", if_none.q, 16'h0000);
        end
        tests_run++;
        if (if_c1.q !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL powerup_c1: got %h expected %h", if_c1.q, 16'h0000);
        end
    endtask

    task automatic test_c0_stream();
        @(negedge clk); #1;
        ce = 1'b1; d0 = 16'h8000; d1 = 16'h7FFF;
        @(posedge clk); #1;
        tests_run++;
        if (if_c0.q !== 16'h8000) begin
            tests_failed++;
            $display("[TB] FAIL c0_pair1_high: got %h expected %h", if_c0.q, 16'h8000);
        end
        @(negedge clk); #1;
        tests_run++;
        if (if_c0.q !== 16'h7FFF) begin
            tests_failed++;
            $display("[TB] FAIL c0_pair1_low: got %h expected %h", if_c0.q, 16'h7FFF);
        end
        d0 = 16'h1234; d1 = 16'hABCD;
        @(posedge clk); #1;
        tests_run++;
        if (if_c0.q !== 16'h1234) begin
            tests_failed++;
            $display("[TB] FAIL c0_pair2_high: got %h expected %h", if_c0.q, 16'h1234);
        end
        d1 = 16'h0000;
        @(negedge clk); #1;
        tests_run++;
        if (if_c0.q !== 16'hABCD) begin
            tests_failed++;
            $display("[TB] FAIL c0_data1_late_change: got %h expected %h", if_c0.q, 16'hABCD);
        end
    endtask

    task automatic test_reset_set();
        logic [1:0]  rs_pat [3] = '{2'b10, 2'b11, 2'b01};
        logic [15:0] rs_exp [3] = '{16'h0000, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 3; i++) begin
            rst = rs_pat[i][1]; set = rs_pat[i][0];
            d0 = (i == 2) ? 16'h1234 : 16'hFFFF;
            d1 = (i == 2) ? 16'h0000 : 16'hFFFF;
            @(posedge clk); #1;
            tests_run++;
            if (if_c0.q !== rs_exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL rst_set_%0d_high: got %h expected %h", i, if_c0.q, rs_exp[i]);
            end
            if (i == 0) begin
                tests_run++;
                if (if_c1.q !== 16'h0000) begin
                    tests_failed++;
                    $display("[TB] FAIL c1_rst_high: got %h expected %h", if_c1.q, 16'h0000);
                end
            end
            @(negedge clk); #1;
            tests_run++;
            if (if_c0.q !== rs_exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL rst_set_%0d_low: got %h expected %h", i, if_c0.q, rs_exp[i]);
            end
        end
        rst = 1'b0; set = 1'b0;
        d0 = 16'h5555; d1 = 16'hAAAA;
        @(posedge clk); #1;
        tests_run++;
        if (if_c0.q !== 16'h5555) begin
            tests_failed++;
            $display("[TB] FAIL after_release_high: got %h expected %h", if_c0.q, 16'h5555);
        end
        @(negedge clk); #1;
        tests_run++;
        if (if_c0.q !== 16'hAAAA) begin
            tests_failed++;
            $display("[TB] FAIL after_release_low: got %h expected %h", if_c0.q, 16'hAAAA);
        end
    endtask

    task automatic test_ce_hold();
        ce = 1'b0; d0 = 16'h0F0F; d1 = 16'hF0F0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (if_c0.q !== 16'hAAAA) begin
                tests_failed++;
                $display("[TB] FAIL ce_hold_%0d_high: got %h expected %h", i, if_c0.q, 16'hAAAA);
            end
            @(negedge clk); #1;
            tests_run++;
            if (if_c0.q !== 16'hAAAA) begin
                tests_failed++;
                $display("[TB] FAIL ce_hold_%0d_low: got %h expected %h", i, if_c0.q, 16'hAAAA);
            end
        end
        ce = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (if_c0.q !== 16'h0F0F) begin
            tests_failed++;
            $display("[TB] FAIL ce_resume_high: got %h expected %h", if_c0.q, 16'h0F0F);
        end
        @(negedge clk); #1;
        tests_run++;
        if (if_c0.q !== 16'hF0F0) begin
            tests_failed++;
            $display("[TB] FAIL ce_resume_low: got %h expected %h", if_c0.q, 16'hF0F0);
        end
    endtask

    task automatic test_none();
        d0 = 16'h0001; d1 = 16'hFFFF;
        @(posedge clk); #1;
        tests_run++;
        if (if_none.q !== 16'h0001) begin
            tests_failed++;
            $display("[TB] FAIL none_high: got %h expected %h", if_none.q, 16'h0001);
        end
        d1 = 16'h0002;
        @(negedge clk); #1;
        tests_run++;
        if (if_none.q !== 16'h0002) begin
            tests_failed++;
            $display("[TB] FAIL none_low: got %h expected %h", if_none.q, 16'h0002);
        end
        tests_run++;
        if (if_c0.q !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL c0_vs_none_low: got %h expected %h", if_c0.q, 16'hFFFF);
        end
    endtask

    task automatic test_c1();
        @(posedge clk); #1;
        d0 = 16'h00FF; d1 = 16'hFF00;
        @(negedge clk); #1;
        d0 = 16'h1111; d1 = 16'h2222;
        @(posedge clk); #1;
        tests_run++;
        if (if_c1.q !== 16'h00FF) begin
            tests_failed++;
            $display("[TB] FAIL c1_pair1_high: got %h expected %h", if_c1.q, 16'h00FF);
        end
        @(negedge clk); #1;
        tests_run++;
        if (if_c1.q !== 16'hFF00) begin
            tests_failed++;
            $display("[TB] FAIL c1_pair1_low: got %h expected %h", if_c1.q, 16'hFF00);
        end
        @(posedge clk); #1;
        tests_run++;
        if (if_c1.q !== 16'h1111) begin
            tests_failed++;
            $display("[TB] FAIL c1_pair2_high: got %h expected %h", if_c1.q, 16'h1111);
        end
        @(negedge clk); #1;
        tests_run++;
        if (if_c1.q !== 16'h2222) begin
            tests_failed++;
            $display("[TB] FAIL c1_pair2_low: got %h expected %h", if_c1.q, 16'h2222);
        end
    endtask

    initial begin
        test_reset();
        test_c0_stream();
        test_reset_set();
        test_ce_hold();
        test_none();
        test_c1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
